handshake_fifo_elastic: RTL and testbench

Elastic FIFO that sits on the receiving end of a dataflow handshake channel, such as the `outs` channel of a constant or operator unit. It accepts tokens on an input valid/ready channel and stores up to `NUM_SLOTS` of them. It re-emits them in order on an output valid/ready channel. This decouples producer and consumer timing, and no combinational path runs from `outs_ready` to `ins_ready`.

---
 rtl/handshake_fifo_elastic.sv | 91 +++++++++
 tb/tb_handshake_fifo_elastic.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_elastic.sv
// ---------------------------------------------------------------------------
// handshake_fifo_elastic
//
// Elastic FIFO on the receive side of a valid/ready dataflow channel. Holds up
// to NUM_SLOTS tokens and re-emits them in order. All outputs come from
// registered state only, so there is no path from outs_ready to ins_ready.
//
// Parameters:
//   DATA_WIDTH - token payload width in bits
//   NUM_SLOTS  - storage depth, 2..64, any value (wrap is explicit)
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   ins        - input payload
//   ins_valid  - producer offers a token
//   ins_ready  - FIFO can accept a token (not full)
//   outs       - head-of-FIFO payload
//   outs_valid - head token available (not empty)
//   outs_ready - consumer accepts the head
// ---------------------------------------------------------------------------
module handshake_fifo_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_full     = (r_count == CNT_FULL);
        w_empty    = (r_count == '0);
        ins_ready  = !w_full;
        outs_valid = !w_empty;
        outs       = r_mem[r_rd_ptr];
        w_push     = ins_valid && !w_full;
        w_pop      = outs_ready && !w_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= ins;
                r_wr_ptr        <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_fifo_elastic.sv
// ---------------------------------------------------------------------------
// tb_handshake_fifo_elastic
//
// Drives three FIFO instances (depths 4, 3 and 5) with identical stimulus and
// compares each against a queue-based reference model of its own depth.
// ---------------------------------------------------------------------------
module tb_handshake_fifo_elastic;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        outs_ready;

    logic        ir_w [NI];
    logic        ov_w [NI];
    logic [31:0] outs_w [NI];

    int          cap [NI] = '{4, 3, 5};
    logic [31:0] mq [NI][$];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    handshake_fifo_elastic #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_d4 (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ir_w[0]), .outs(outs_w[0]), .outs_valid(ov_w[0]),
        .outs_ready(outs_ready)
    );
    handshake_fifo_elastic #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_d3 (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ir_w[1]), .outs(outs_w[1]), .outs_valid(ov_w[1]),
        .outs_ready(outs_ready)
    );
    handshake_fifo_elastic #(.DATA_WIDTH(32), .NUM_SLOTS(5)) u_d5 (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ir_w[2]), .outs(outs_w[2]), .outs_valid(ov_w[2]),
        .outs_ready(outs_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Check all instances against the model, apply one cycle of stimulus,
    // update the model at the clock edge, and return at the next falling edge.
    task automatic step(input logic r, input logic vin, input logic [31:0] din,
                        input logic rdy);
        bit push [NI];
        bit pop  [NI];
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("d%0d ins_ready", cap[k]), 32'(ir_w[k]),
                32'(mq[k].size() < cap[k]));
            chk($sformatf("d%0d outs_valid", cap[k]), 32'(ov_w[k]),
                32'(mq[k].size() > 0));
            if (mq[k].size() > 0)
                chk($sformatf("d%0d outs", cap[k]), outs_w[k], mq[k][0]);
            push[k] = vin && (mq[k].size() < cap[k]);
            pop[k]  = rdy && (mq[k].size() > 0);
        end
        rst        = r;
        ins_valid  = vin;
        ins        = din;
        outs_ready = rdy;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                mq[k].delete();
            end else begin
                if (pop[k])  void'(mq[k].pop_front());
                if (push[k]) mq[k].push_back(din);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s d%0d ins_ready", tag, cap[k]), 32'(ir_w[k]), 32'd1);
            chk($sformatf("%s d%0d outs_valid", tag, cap[k]), 32'(ov_w[k]), 32'd0);
            chk($sformatf("%s d%0d outs", tag, cap[k]), outs_w[k], 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) mq[k].delete();

        // Idle after reset.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_reset_state("idle");
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end

        // Single token with consumer ready.
        step(1'b0, 1'b1, 32'h9, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_reset_state("after single");

        // Fill, hold an extra offer against backpressure, then drain.
        for (int v = 1; v <= 4; v++) step(1'b0, 1'b1, 32'(v), 1'b0);
        chk("d4 full ins_ready", 32'(ir_w[0]), 32'd0);
        step(1'b0, 1'b1, 32'h5, 1'b0);
        step(1'b0, 1'b1, 32'h5, 1'b0);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming 0..99 with the consumer always ready.
        for (int v = 0; v < 100; v++) step(1'b0, 1'b1, 32'(v), 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random valid/ready, 50% each.
        for (int c = 0; c < 2000; c++)
            step(1'b0, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));

        // Reset mid-operation during a simultaneous push and pop.
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int v = 0; v < 3; v++) step(1'b0, 1'b1, 32'hA0 + 32'(v), 1'b0);
        step(1'b1, 1'b1, 32'hBEEF, 1'b1);
        chk_reset_state("midrst");
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_reset_state("post midrst");
        step(1'b0, 1'b1, 32'h77, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
